// File: rtl/ex_iter_divider.sv
// ex_iter_divider: multi-cycle restoring divider for DIV/DIVU in the EX stage.
// It produces one quotient bit per cycle, followed by a single DONE cycle.
// The result is {remainder, quotient}.
// The stall output holds the divide instruction in EX until its result is ready.
module ex_iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic               flush,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               stall,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result_x64
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   dvd_raw_q, dvd_raw_d;
    logic               quo_neg_q, quo_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div_zero_q, div_zero_d;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    // Operand conditioning and one restoring-division step.
    logic [WIDTH-1:0]   dvd_abs, dvs_abs;
    logic [WIDTH:0]     shifted, diff;
    logic               fits;
    logic [WIDTH-1:0]   rem_next, quo_next, rem_fix, quo_fix;

    // Compute the absolute operands, the trial subtraction and the sign fix-up.
    always_comb begin
        dvd_abs  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        // The partial remainder is always below the divisor.
        // So the shifted value fits in WIDTH+1 bits.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        fits     = ~diff[WIDTH];
        rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], fits};
        quo_fix  = quo_neg_q ? -quo_next : quo_next;
        rem_fix  = rem_neg_q ? -rem_next : rem_next;
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        dvd_raw_d  = dvd_raw_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        count_d    = count_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        result_d   = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d    = S_RUN;
                    busy_d     = 1'b1;
                    rem_d      = '0;
                    quo_d      = dvd_abs;
                    dvs_d      = dvs_abs;
                    dvd_raw_d  = dividend;
                    quo_neg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rem_neg_d  = is_signed & dividend[WIDTH-1];
                    div_zero_d = (divisor == '0);
                    count_d    = '0;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d   = rem_next;
                    quo_d   = quo_next;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_COUNT) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        // A zero divisor yields an all-ones quotient and the raw dividend.
                        // This overrides the sign fix-up.
                        result_d = div_zero_q ? {dvd_raw_q, {WIDTH{1'b1}}}
                                              : {rem_fix, quo_fix};
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, with an asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            dvd_raw_q  <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            dvd_raw_q  <= dvd_raw_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    // The stall must be raised in the same cycle that start arrives, so it is combinational.
    assign stall      = ((state_q == S_IDLE) && start && !flush) || (state_q == S_RUN);
    assign busy       = busy_q;
    assign done       = done_q;
    assign result_x64 = result_q;

endmodule

// File: tb/tb_ex_iter_divider.sv
// tb_ex_iter_divider: directed checks of the iterative divider.
// It covers latency, signed and unsigned results, divide by zero, flush and async reset.
module tb_ex_iter_divider;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic        flush;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        stall;
    logic        busy;
    logic        done;
    logic [63:0] result_x64;

    int total = 0;
    int bad   = 0;

    ex_iter_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .is_signed  (is_signed),
        .flush      (flush),
        .dividend   (dividend),
        .divisor    (divisor),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result_x64 (result_x64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one divide and wait for done, with a bounded wait.
    // When scramble is set, the operands are changed while the divider is busy.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit scramble);
        logic [63:0] prev;
        int          cyc;
        int          bad_cyc;
        bit          seen;
        prev      = result_x64;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        #1;
        chk({tag, "_stall_c0"}, 64'(stall), 64'd1);
        seen    = 1'b0;
        cyc     = 0;
        bad_cyc = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (!(stall === 1'b1 && busy === 1'b1 && result_x64 === prev))
                    bad_cyc++;
                if (scramble) begin
                    dividend  = $urandom;
                    divisor   = $urandom;
                    is_signed = ~is_signed;
                end
            end
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, 64'(cyc), 64'd33);
        chk({tag, "_run_cycles"}, 64'(bad_cyc), 64'd0);
        chk({tag, "_stall_done"}, 64'(stall), 64'd0);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        chk({tag, "_result"}, result_x64, exp);
        $display("op %s: done_cycle=%0d result_x64=%h", tag, cyc, result_x64);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, result_x64, exp);
    endtask

    initial begin
        logic [63:0] held;
        int          done_cnt;
        reset_n   = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        flush     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_result", result_x64, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("divu_100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 1'b0);
        run_op("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_op("div_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1'b0);
        run_op("div_m7_m2",   1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 1'b0);
        run_op("div_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1'b0);
        run_op("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 1'b0);
        run_op("divu_m7_2",   1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 1'b0);
        run_op("divu_by0",    1'b0, 32'd1234,       32'd0,          64'h000004D2_FFFFFFFF, 1'b0);
        run_op("div_by0",     1'b1, 32'hFFFFFFF9,   32'd0,          64'hFFFFFFF9_FFFFFFFF, 1'b0);

        // When start and flush arrive together in IDLE, flush wins.
        is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        start = 1'b1; flush = 1'b1;
        #1;
        chk("sf_idle_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        chk("sf_idle_busy", 64'(busy), 64'd0);
        start = 1'b0; flush = 1'b0;
        $display("op start_with_flush: busy=%0d", busy);

        // Flush in the middle of RUN: no done pulse, and the result is kept.
        held = result_x64;
        is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        chk("fl_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        chk("fl_busy_after", 64'(busy), 64'd0);
        chk("fl_stall_after", 64'(stall), 64'd0);
        flush = 1'b0; start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        chk("fl_no_done", 64'(done_cnt), 64'd0);
        chk("fl_result_kept", result_x64, held);
        $display("op flush_mid_run: done_pulses=%0d result_x64=%h", done_cnt, result_x64);
        run_op("divu_9_3",    1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 1'b0);

        // Asynchronous reset applied between edges, in the middle of RUN.
        is_signed = 1'b0; dividend = 32'd77; divisor = 32'd4; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        chk("ar_result", result_x64, 64'd0);
        start = 1'b0;
        #1;
        chk("ar_stall", 64'(stall), 64'd0);
        $display("op async_reset: busy=%0d result_x64=%h", busy, result_x64);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op("divu_scr",    1'b0, 32'd1000,       32'd10,         64'h00000000_00000064, 1'b1);
        run_op("div_scr",     1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
